// File: rtl/bitrev_reorder_buf_if.sv
// Stream handshake bundle (valid/ready/data) for bitrev_reorder_buf.
// The master drives valid/data and samples ready; the slave drives ready.
// Optional macro REORDER_LAST_EN adds a 'last' flag on the stream.
interface bitrev_reorder_buf_if #(
    parameter int width = 16
);
    logic             valid;
    logic             ready;
    logic [width-1:0] data;
`ifdef REORDER_LAST_EN
    logic             last;
`endif

`ifdef REORDER_LAST_EN
    modport master (output valid, output data, output last, input ready);
`else
    modport master (output valid, output data, input ready);
`endif
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bitrev_reorder_buf.sv
// bitrev_reorder_buf: ping-pong frame buffer that accepts samples in natural
// index order and returns each N = 2**LOG2N sample frame in bit-reversed order.
// One bank fills while the other drains, so both sides can stream at one
// sample per cycle indefinitely.
// Optional macro REORDER_LAST_EN: adds out_last (as out_if.last), high on the
// final sample of each reordered frame.
// All handshake outputs are registered: they are computed from next state, so
// they equal the purely state-derived values (in_ready = !full[wbank],
// out_valid = full[rbank]) while being driven straight from flops.
module bitrev_reorder_buf #(
    parameter int width = 16,
    parameter int LOG2N = 3
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       flush,
    bitrev_reorder_buf_if.slave        in_if,
    bitrev_reorder_buf_if.master       out_if
);

    localparam int N = 1 << LOG2N;
    typedef logic [LOG2N-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(N - 1);

    // Reverse the LOG2N index bits.
    function automatic idx_t bitrev(input idx_t v);
        idx_t r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [width-1:0] mem_q [2][N];

    logic             wbank_q, wbank_d;
    idx_t             wcnt_q,  wcnt_d;
    logic             rbank_q, rbank_d;
    idx_t             rcnt_q,  rcnt_d;
    logic [1:0]       full_q,  full_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [width-1:0] out_data_q,  out_data_d;
`ifdef REORDER_LAST_EN
    logic             out_last_q,  out_last_d;
`endif

    logic             wr_fire_s;
    logic             rd_fire_s;
    logic             mem_we_s;
    idx_t             rd_addr_s;
    logic [width-1:0] rd_word_s;

    // Next-state for bank pointers, counters, full flags, and registered outputs.
    always_comb begin
        wbank_d   = wbank_q;
        wcnt_d    = wcnt_q;
        rbank_d   = rbank_q;
        rcnt_d    = rcnt_q;
        full_d    = full_q;
        mem_we_s  = 1'b0;
        wr_fire_s = in_if.valid && in_ready_q;
        rd_fire_s = out_valid_q && out_if.ready;

        if (flush) begin
            // Flush wins over any same-cycle beat on either side.
            wbank_d = 1'b0;
            wcnt_d  = '0;
            rbank_d = 1'b0;
            rcnt_d  = '0;
            full_d  = 2'b00;
        end else begin
            if (wr_fire_s) begin
                mem_we_s = 1'b1;
                wcnt_d   = wcnt_q + idx_t'(1);
                if (wcnt_q == LAST_IDX) begin
                    full_d[wbank_q] = 1'b1;
                    wbank_d         = ~wbank_q;
                end else begin
                    wbank_d = wbank_q;
                end
            end else begin
                mem_we_s = 1'b0;
            end

            if (rd_fire_s) begin
                rcnt_d = rcnt_q + idx_t'(1);
                if (rcnt_q == LAST_IDX) begin
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = ~rbank_q;
                end else begin
                    rbank_d = rbank_q;
                end
            end else begin
                rcnt_d = rcnt_q;
            end
        end

        // Word presented next cycle; forward the word being written this
        // cycle in case it lands on the address about to be presented.
        rd_addr_s = bitrev(rcnt_d);
        if (mem_we_s && (wbank_q == rbank_d) && (wcnt_q == rd_addr_s)) begin
            rd_word_s = in_if.data;
        end else begin
            rd_word_s = mem_q[rbank_d][rd_addr_s];
        end

        in_ready_d  = !full_d[wbank_d];
        out_valid_d = full_d[rbank_d];
        if (out_valid_d) begin
            out_data_d = rd_word_s;
        end else begin
            out_data_d = '0;
        end
`ifdef REORDER_LAST_EN
        out_last_d = out_valid_d && (rcnt_d == LAST_IDX);
`endif
    end

    // Control state and output registers with async reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wbank_q     <= 1'b0;
            wcnt_q      <= '0;
            rbank_q     <= 1'b0;
            rcnt_q      <= '0;
            full_q      <= 2'b00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef REORDER_LAST_EN
            out_last_q  <= 1'b0;
`endif
        end else begin
            wbank_q     <= wbank_d;
            wcnt_q      <= wcnt_d;
            rbank_q     <= rbank_d;
            rcnt_q      <= rcnt_d;
            full_q      <= full_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef REORDER_LAST_EN
            out_last_q  <= out_last_d;
`endif
        end
    end

    // Sample storage; contents need no reset since full flags gate visibility.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wbank_q][wcnt_q] <= in_if.data;
        end
    end

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;
`ifdef REORDER_LAST_EN
    assign out_if.last  = out_last_q;
`endif

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Table-driven bench for bitrev_reorder_buf (LOG2N=3, width=16).
// Each row drives one cycle of inputs and lists the outputs expected
// in that cycle, before the next rising edge.
module tb_bitrev_reorder_buf;

    logic clk;
    logic clr_n;
    logic flush;

    bitrev_reorder_buf_if #(.width(16)) in_if ();
    bitrev_reorder_buf_if #(.width(16)) out_if ();

    bitrev_reorder_buf #(.width(16), .LOG2N(3)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .flush  (flush),
        .in_if  (in_if),
        .out_if (out_if)
    );

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        fl;
        logic        e_rdy;
        logic        e_v;
        logic [15:0] e_d;
        logic        e_last;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;
    int   br[8]    = '{0, 4, 2, 6, 1, 5, 3, 7};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic iv, input int id, input logic ordy, input logic fl,
                       input logic er, input logic ev, input int ed, input logic el);
        vec_t v;
        v.iv = iv; v.id = 16'(id); v.ordy = ordy; v.fl = fl;
        v.e_rdy = er; v.e_v = ev; v.e_d = 16'(ed); v.e_last = el;
        vq.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            in_if.valid  = vq[k].iv;
            in_if.data   = vq[k].id;
            out_if.ready = vq[k].ordy;
            flush        = vq[k].fl;
            chk($sformatf("%s[%0d].in_ready", tag, k), 32'(in_if.ready), 32'(vq[k].e_rdy));
            chk($sformatf("%s[%0d].out_valid", tag, k), 32'(out_if.valid), 32'(vq[k].e_v));
            chk($sformatf("%s[%0d].out_data", tag, k), 32'(out_if.data), 32'(vq[k].e_d));
`ifdef REORDER_LAST_EN
            chk($sformatf("%s[%0d].out_last", tag, k), 32'(out_if.last), 32'(vq[k].e_last));
`endif
        end
        @(negedge clk);
        in_if.valid  = 1'b0;
        in_if.data   = 16'd0;
        out_if.ready = 1'b0;
        flush        = 1'b0;
        vq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n        = 1'b0;
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = 16'd0;
        out_if.ready = 1'b0;
        #12;
        chk("reset.in_ready", 32'(in_if.ready), 32'd1);
        chk("reset.out_valid", 32'(out_if.valid), 32'd0);
        chk("reset.out_data", 32'(out_if.data), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;

        // Single frame at full rate.
        for (int k = 0; k < 8; k++) add(1'b1, k, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 8; k++) add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, br[k], k == 7);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_vecs("single");
        do_reset();

        // Streaming: four back-to-back frames, no bubble on either side.
        for (int c = 0; c < 41; c++) begin
            int  p;
            logic v;
            p = c - 8;
            v = (c >= 8) && (c < 40);
            add(c < 32, (c < 32) ? c : 0, 1'b1, 1'b0, 1'b1, v,
                v ? ((p / 8) * 8 + br[p % 8]) : 0, v && ((p % 8) == 7));
        end
        run_vecs("stream");
        do_reset();

        // Backpressure: both banks fill, 17th attempt refused.
        for (int k = 0; k < 17; k++) add(1'b1, k, 1'b0, 1'b0, k < 16, k >= 8, 0, 1'b0);
        for (int j = 0; j < 8; j++) add(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, br[j], j == 7);
        add(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        add(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        for (int j = 0; j < 8; j++) add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 8 + br[j], j == 7);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_vecs("backpr");
        do_reset();

        // Stall hold: out_ready pattern 1,0,0,1 then steady.
        for (int k = 0; k < 8; k++) add(1'b1, k, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        add(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        add(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        for (int j = 2; j < 8; j++) add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, br[j], j == 7);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_vecs("stall");
        do_reset();

        // Flush with a full bank and a partial bank, plus same-cycle beats.
        for (int k = 0; k < 8; k++) add(1'b1, k, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int k = 8; k < 11; k++) add(1'b1, k, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        add(1'b1, 11, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        for (int k = 0; k < 8; k++) add(1'b1, 100 + k, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int j = 0; j < 8; j++) add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 100 + br[j], j == 7);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_vecs("flush");
        do_reset();

        // Mid-frame asynchronous reset after a partial frame 0..4.
        for (int k = 0; k < 5; k++) add(1'b1, k, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_vecs("prerst");
        #2;
        clr_n = 1'b0;
        #1;
        chk("midrst.in_ready", 32'(in_if.ready), 32'd1);
        chk("midrst.out_valid", 32'(out_if.valid), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst.hold_valid", 32'(out_if.valid), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 0; k < 8; k++) add(1'b1, 100 + k, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int j = 0; j < 8; j++) add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 100 + br[j], j == 7);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_vecs("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
